// File: rtl/chr_mem_port_if.sv
// SDRAM controller port bundle for chr_mem_port.
//   master : the bridge (drives req/we/address/data/mask, receives read data + ack)
//   slave  : the SDRAM arbiter side
interface chr_mem_port_if #(
  parameter int ADDR_BITS = 23
);
  logic                 ram_req;
  logic                 ram_we;
  logic [ADDR_BITS-2:0] ram_address;
  logic [15:0]          ram_data_write;
  logic [1:0]           ram_wm;
  logic [15:0]          ram_data_read;
  logic                 ram_ack;

  modport master (
    output ram_req, ram_we, ram_address, ram_data_write, ram_wm,
    input  ram_data_read, ram_ack
  );

  modport slave (
    input  ram_req, ram_we, ram_address, ram_data_write, ram_wm,
    output ram_data_read, ram_ack
  );
endinterface

// File: rtl/chr_mem_port.sv
// Cartridge CHR bus to 16-bit SDRAM port bridge.
// One-word read cache with write-through, posted write queue, same-word
// read-after-write ordering, sticky overflow on a dropped write.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   addr, data_in     cartridge byte address / write data (asynchronous)
//   ce, oe, we        cartridge strobes (oe active-low, we active-high)
//   data_out          byte of the cached word selected by live addr[0]
//   ram               SDRAM port (chr_mem_port_if.master)
//   busy              FSM active, queue non-empty or a read pending
//   overflow          sticky: a write was dropped on a full queue
module chr_mem_port #(
  parameter int ADDR_BITS     = 23,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int WQ_DEPTH      = 4
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 ce,
  input  logic                 oe,
  input  logic                 we,
  chr_mem_port_if.master       ram,
  output logic                 busy,
  output logic                 overflow
);

  localparam int           WA       = ADDR_BITS - 1;
  localparam int           QW       = $clog2(WQ_DEPTH);
  localparam logic [2:0]   STABLE_N = 3'(STABLE_CYCLES);
  localparam logic [QW:0]  Q_FULL   = (QW+1)'(WQ_DEPTH);

  typedef struct packed {
    logic [WA-1:0] word;
    logic          hi;    // byte lane: addr[0]
    logic [7:0]    dat;
  } wq_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0]                rd_sync, wr_sync;
  logic [SYNC_STAGES:0][ADDR_BITS-1:0]   gray_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync   <= '0;
      wr_sync   <= '0;
      gray_sync <= '0;
    end else begin
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], ce & ~oe};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], ce & we};
      gray_sync <= {gray_sync[SYNC_STAGES-1:0], addr ^ (addr >> 1)};
    end
  end

  logic rd_s, wr_s;
  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];

  // Gray decode of the oldest sample; only the word bits are needed.
  logic [WA-1:0] s_word;
  always_comb begin
    s_word = '0;
    for (int i = 0; i < WA; i++)
      s_word[i] = ^(gray_sync[SYNC_STAGES] >> (i + 1));
  end

  // ----------------------------------------------------- write capture
  logic                 wr_prev, wr_fall;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev <= 1'b0;
      wr_addr <= '0;
      wr_byte <= '0;
    end else begin
      wr_prev <= wr_s;
      if (wr_s) begin
        wr_addr <= addr;
        wr_byte <= data_in;
      end
    end
  end

  assign wr_fall = wr_prev & ~wr_s;

  wq_t push_ent;
  assign push_ent = '{word: wr_addr[ADDR_BITS-1:1], hi: wr_addr[0], dat: wr_byte};

  // ------------------------------------------------ stability counter
  logic [2:0] cnt;
  logic       stable, rd_taken, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rd_taken <= 1'b0;
    end else begin
      if (wr_fall || !rd_s)
        cnt <= '0;
      else if (gray_sync[SYNC_STAGES] == gray_sync[SYNC_STAGES-1]) begin
        if (cnt != STABLE_N) cnt <= cnt + 3'd1;
      end else
        cnt <= 3'd1;
      // one accept per stable window; re-arms once stable drops
      rd_taken <= stable;
    end
  end

  assign stable = (cnt == STABLE_N);
  assign accept = stable & ~rd_taken;

  // ------------------------------------------------------------- state
  state_t          state, state_nx;
  logic [15:0]     cache;
  logic [WA-1:0]   tag;
  logic            cache_valid;
  logic            pend_valid;
  logic [WA-1:0]   pend_word;
  logic [WA-1:0]   rd_word;      // word of the read in flight
  logic [1:0]      ovr_mask;     // bytes written to rd_word while in flight
  logic [15:0]     ovr_data;

  wq_t             q_mem [WQ_DEPTH];
  logic [QW-1:0]   wptr, rptr;
  logic [QW:0]     q_cnt;
  wq_t             head;

  logic hit, load, push, pop, drop, fill, hazard;
  logic issue_rd, issue_wr;
  logic [15:0] fill_data;

  assign head = q_mem[rptr];
  assign hit  = cache_valid && (tag == s_word);
  assign load = accept && !hit;
  assign pop  = (state == WR_WAIT) && ram.ram_ack;
  assign fill = (state == RD_WAIT) && ram.ram_ack;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign push = wr_fall && ((q_cnt != Q_FULL) || pop);
  assign drop = wr_fall && (q_cnt == Q_FULL) && !pop;

  // A pending read must not pass any queued write to the same word,
  // including one being pushed this cycle.
  always_comb begin
    hazard = push && (push_ent.word == pend_word);
    for (int k = 0; k < WQ_DEPTH; k++)
      if (((QW+1)'(k) < q_cnt) && (q_mem[QW'(rptr + QW'(k))].word == pend_word))
        hazard = 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (issue_rd)      state_nx = RD_WAIT;
               else if (issue_wr) state_nx = WR_WAIT;
      RD_WAIT,
      WR_WAIT: if (ram.ram_ack)   state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // FSM: outputs (issue decisions, registered onto the port below)
  always_comb begin
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    if (state == IDLE) begin
      if (pend_valid && !hazard) issue_rd = 1'b1;
      else if (q_cnt != '0)      issue_wr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram.ram_req        <= 1'b0;
      ram.ram_we         <= 1'b0;
      ram.ram_address    <= '0;
      ram.ram_data_write <= '0;
      ram.ram_wm         <= '0;
    end else begin
      ram.ram_req <= issue_rd | issue_wr;
      if (issue_rd) begin
        ram.ram_we      <= 1'b0;
        ram.ram_address <= pend_word;
      end else if (issue_wr) begin
        ram.ram_we         <= 1'b1;
        ram.ram_address    <= head.word;
        ram.ram_data_write <= {head.dat, head.dat};
        ram.ram_wm         <= head.hi ? 2'b01 : 2'b10;
      end
    end
  end

  // ------------------------------------------------------- write queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      q_cnt    <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < WQ_DEPTH; k++) q_mem[k] <= '0;
    end else begin
      if (push) begin
        q_mem[wptr] <= push_ent;
        wptr        <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // ------------------------------------------------- pending read slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      rd_word    <= '0;
    end else begin
      if (load) begin
        pend_valid <= 1'b1;
        pend_word  <= s_word;
      end else if (fill && (pend_word == rd_word))
        pend_valid <= 1'b0;   // a newer miss to another word stays pending
      if (issue_rd) rd_word <= pend_word;
    end
  end

  // Writes to the in-flight word win over the returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_mask <= '0;
      ovr_data <= '0;
    end else if (issue_rd) begin
      ovr_mask <= '0;
    end else if ((state == RD_WAIT) && push && (push_ent.word == rd_word)) begin
      if (push_ent.hi) begin
        ovr_mask[1]     <= 1'b1;
        ovr_data[15:8]  <= push_ent.dat;
      end else begin
        ovr_mask[0]     <= 1'b1;
        ovr_data[7:0]   <= push_ent.dat;
      end
    end
  end

  always_comb begin
    fill_data = ram.ram_data_read;
    if (ovr_mask[0]) fill_data[7:0]  = ovr_data[7:0];
    if (ovr_mask[1]) fill_data[15:8] = ovr_data[15:8];
    if (push && (push_ent.word == rd_word)) begin
      if (push_ent.hi) fill_data[15:8] = push_ent.dat;
      else             fill_data[7:0]  = push_ent.dat;
    end
  end

  // ------------------------------------------------------------- cache
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache       <= '0;
      tag         <= '0;
      cache_valid <= 1'b0;
    end else if (fill) begin
      cache       <= fill_data;
      tag         <= rd_word;
      cache_valid <= 1'b1;
    end else if (push && cache_valid && (tag == push_ent.word)) begin
      if (push_ent.hi) cache[15:8] <= push_ent.dat;
      else             cache[7:0]  <= push_ent.dat;
    end
  end

  assign data_out = addr[0] ? cache[15:8] : cache[7:0];
  assign busy     = (state != IDLE) || (q_cnt != '0) || pend_valid;

endmodule

// File: doc/chr_mem_port.md
Name: chr_mem_port

Overview:
- Parametrised bridge between the asynchronous cartridge CHR bus (ce/oe/we strobes, byte data) and one 16-bit SDRAM controller port.
- Successor to the single-transaction CHR RAM front end. Adds a ram_ack completion handshake, a one-word read cache with write-through update, and a posted write queue so writes are never blocked by reads in flight.
- Adds read-after-write hazard ordering and sticky overflow reporting.
- Sits between the cartridge pin synchronisers and the SDRAM arbiter.

Parameters:
- ADDR_BITS, 23, byte address width (SDRAM word address width + 1).
- SYNC_STAGES, 2, synchroniser depth for the strobes and the gray-coded address (min 2).
- STABLE_CYCLES, 3, consecutive equal address samples required before a read is accepted (1..7).
- WQ_DEPTH, 4, write queue entries (power of 2, min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_BITS  cartridge byte address (asynchronous)
- data_in  in  8  cartridge write data (asynchronous)
- data_out  out  8  read byte
- ce  in  1  chip enable (asynchronous)
- oe  in  1  output enable, active-low (asynchronous)
- we  in  1  write enable, active-high (asynchronous)
- ram_req  out  1  one-cycle request pulse
- ram_we  out  1  1=write, 0=read; valid with ram_req
- ram_address  out  ADDR_BITS-1  word address
- ram_data_write  out  16  write data
- ram_wm  out  2  write byte mask, 1=masked
- ram_data_read  in  16  read data; valid on the ram_ack cycle
- ram_ack  in  1  one-cycle completion of the outstanding request
- busy  out  1  state!=IDLE, or queue non-empty, or read pending
- overflow  out  1  sticky: a write was dropped because the queue was full

Behaviour:
- Reset (async assert, sync release):
  - Cache is invalid; queue is empty; no read is pending; FSM is IDLE.
  - ram_req, ram_we, ram_wm, ram_address, ram_data_write, overflow and the stability counter are all 0.
  - data_out shows cache bytes, which are 0 after reset.
- Sync:
  - rd = ce && !oe and wr = ce && we each pass through SYNC_STAGES flops.
  - The address is gray-coded (a ^ a>>1) and passes through SYNC_STAGES+1 flops.
- Stability counter:
  - Held at 0 while synced rd is low.
  - While rd is high: if the last two gray samples are equal, increment, saturating at STABLE_CYCLES; otherwise load 1.
  - stable = (cnt == STABLE_CYCLES).
  - A read is accepted on the first cycle of stable per access; it re-arms only after stable drops.
- Accepted read, word address W = addr[ADDR_BITS-1:1]:
  - Cache valid and tag == W: hit, no SDRAM traffic.
  - Otherwise: miss. Load the pending-read slot with W, overwriting any older pending read.
- Write capture:
  - While synced wr is high, register addr and data_in every cycle.
  - On the synced wr falling edge (prev=1, cur=0), push {W, addr[0], byte} into the queue and zero the stability counter.
  - If the queue is full, drop the write and set overflow (sticky until reset).
  - On push, if cache valid and tag == W, update the addressed cache byte in the same cycle (write-through).
- FSM:
  - IDLE: if a read is pending and no queue entry has word == W, issue the read (ram_req=1, ram_we=0, ram_address=W) and go to RD_WAIT. Else if the queue is non-empty, issue its head (ram_we=1, ram_data_write={byte,byte}, ram_wm = addr0 ? 2'b01 : 2'b10) and go to WR_WAIT.
  - Read priority applies except on a same-word hazard; the queue drains until no entry matches.
  - RD_WAIT, on ram_ack: cache <= ram_data_read, tag <= W, valid <= 1, clear pending, go to IDLE.
  - If a write to tag W was pushed during RD_WAIT, that byte overrides ram_data_read at fill.
  - WR_WAIT, on ram_ack: pop the head, go to IDLE.
  - ram_ack in IDLE is ignored.
- ram_req is high exactly one cycle per transaction. Output fields hold until the next request.
- At most one outstanding transaction at any time.
- data_out = addr[0] ? cache[15:8] : cache[7:0], combinational on live addr[0]. Sub-word toggles need no new SDRAM read.
- If the read strobe ends before ram_ack, the transaction still completes and the cache still fills.
- Push and pop in the same cycle: allowed at full; count is unchanged; overflow is not set.
- Queue pointers wrap modulo WQ_DEPTH.
- Reset mid-transaction clears everything; a later ram_ack is ignored.

Test Plan:
- Read 0x000102, SDRAM returns 0xBEEF on ram_ack 4 cycles after ram_req -> one req with ram_we=0, ram_address=0x000081; data_out=0xEF; then addr 0x000103 gives data_out=0xBE with no new req.
- Address glitches every 2 cycles during a read, STABLE_CYCLES=3 -> no ram_req until the address holds 3 equal samples; exactly one req per strobe.
- Write 0x5A to 0x000103 while the cached tag is 0x000081 -> cache high byte=0x5A immediately; write req with ram_wm=2'b01, ram_data_write=0x5A5A.
- Five back-to-back writes with ram_ack withheld, WQ_DEPTH=4 -> fifth write dropped, overflow=1, first four issued in order after the acks arrive.
- Write queued to word 0x40, then read miss on word 0x40 -> write req issued before read req; read miss on word 0x41 instead -> read req issued first.
- Assert rst_n=0 in RD_WAIT, then pulse ram_ack -> ram_req=0, busy=0, cache invalid; next read issues a fresh req.
